tinyriscv_lsu: RTL and testbench

Load/store unit directly downstream of the execute-stage ALU. It takes the ALU's effective address (`res`) and store data (`byp`) for LOAD/STORE opcodes, runs one valid/ready transaction on the data-memory port, and aligns and extends the load data for writeback. It also raises misaligned, illegal-funct3 and bus-error exceptions. Only one access is outstanding at a time.

---
 rtl/tinyriscv_lsu_pkg.sv | 48 ++++
 rtl/tinyriscv_lsu_align.sv | 41 ++++
 rtl/tinyriscv_lsu.sv | 154 +++++++++++++++
 tb/tb_tinyriscv_lsu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_lsu_pkg.sv
// Shared types and encodings for the tinyriscv load/store unit.
// Opcode and funct3 values mirror the RV32I base encoding.
package tinyriscv_lsu_pkg;

   localparam int unsigned RISCV_CONFIG_XLEN = 32;

   localparam logic [6:0] RISCV_RV32I_OPCODE_LOAD  = 7'b0000011;
   localparam logic [6:0] RISCV_RV32I_OPCODE_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // funct3[1:0] selects access width, funct3[2] selects zero-extension
   localparam logic [1:0] F3_SIZE_B = 2'b00;
   localparam logic [1:0] F3_SIZE_H = 2'b01;
   localparam logic [1:0] F3_SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      EXC_NONE       = 2'd0,
      EXC_MISALIGNED = 2'd1,
      EXC_ILLEGAL    = 2'd2,
      EXC_BUS        = 2'd3
   } exc_cause_e;

   function automatic logic funct3_illegal(input logic is_store, input logic [2:0] f3);
      if (is_store) return (f3 >= 3'd3);
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         F3_SIZE_H: return lo[0];
         F3_SIZE_W: return (lo != 2'b00);
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/tinyriscv_lsu_align.sv
// Combinational lane logic: byte enables, store replication and
// load shift/extension for a 32-bit data bus.
module tinyriscv_lsu_align
   import tinyriscv_lsu_pkg::*;
#(
   parameter int unsigned XLEN = RISCV_CONFIG_XLEN
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [3:0]      be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o
);

   logic [XLEN-1:0] shifted;
   logic            sext;

   always_comb begin
      shifted = rdata_i >> {addr_lo_i, 3'b000};
      sext    = ~funct3_i[2];
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = shifted;
      case (funct3_i[1:0])
         F3_SIZE_B: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
         end
         F3_SIZE_H: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{sext & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/tinyriscv_lsu.sv
// Load/store unit: one outstanding valid/ready access on the data port,
// aligned writeback and misaligned/illegal/bus-error exceptions.
module tinyriscv_lsu
   import tinyriscv_lsu_pkg::*;
#(
   parameter int unsigned XLEN = RISCV_CONFIG_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [6:0]      req_opcode,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [4:0]      req_rd,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_err,
   output logic            wb_valid,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            exc,
   output logic [1:0]      exc_cause
);

   lsu_state_e      state_q;
   exc_cause_e      exc_cause_q;
   logic            req_ready_q, mem_valid_q, mem_we_q, wb_valid_q, wb_we_q, exc_q;
   logic [XLEN-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
   logic [3:0]      mem_be_q;
   logic [4:0]      wb_rd_q, rd_q;
   logic [2:0]      funct3_q;
   logic [1:0]      addr_lo_q;
   logic            store_q;

   logic            accept, req_store, req_illegal, req_misaligned;
   logic [2:0]      align_f3;
   logic [1:0]      align_lo;
   logic [3:0]      align_be;
   logic [XLEN-1:0] align_wdata, align_rdata;

   assign accept         = req_valid & req_ready_q;
   assign req_store      = (req_opcode == RISCV_RV32I_OPCODE_STORE);
   assign req_illegal    = funct3_illegal(req_store, req_funct3);
   assign req_misaligned = addr_misaligned(req_funct3, req_addr[1:0]);

   // One aligner serves both directions: store lanes from the live request
   // while idle, load extension from the captured request while waiting.
   assign align_f3 = (state_q == ST_IDLE) ? req_funct3    : funct3_q;
   assign align_lo = (state_q == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

   tinyriscv_lsu_align #(.XLEN(XLEN)) u_align (
      .funct3_i  (align_f3),
      .addr_lo_i (align_lo),
      .wdata_i   (req_wdata),
      .rdata_i   (mem_rdata),
      .be_o      (align_be),
      .wdata_o   (align_wdata),
      .rdata_o   (align_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         exc_q       <= 1'b0;
         exc_cause_q <= EXC_NONE;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
         rd_q        <= '0;
         store_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) begin
               req_ready_q <= 1'b0;
               funct3_q    <= req_funct3;
               addr_lo_q   <= req_addr[1:0];
               rd_q        <= req_rd;
               store_q     <= req_store;
               if (req_illegal || req_misaligned) begin
                  state_q     <= ST_DONE;
                  wb_valid_q  <= 1'b1;
                  exc_q       <= 1'b1;
                  exc_cause_q <= req_illegal ? EXC_ILLEGAL : EXC_MISALIGNED;
               end else begin
                  state_q     <= ST_REQ;
                  mem_valid_q <= 1'b1;
                  mem_we_q    <= req_store;
                  mem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
                  mem_be_q    <= align_be;
                  mem_wdata_q <= req_store ? align_wdata : '0;
               end
            end
            ST_REQ: if (mem_ready) begin
               state_q     <= ST_WAIT;
               mem_valid_q <= 1'b0;
            end
            ST_WAIT: if (mem_rvalid) begin
               state_q    <= ST_DONE;
               wb_valid_q <= 1'b1;
               if (mem_err) begin
                  exc_q       <= 1'b1;
                  exc_cause_q <= EXC_BUS;
               end else if (!store_q) begin
                  wb_we_q   <= 1'b1;
                  wb_rd_q   <= rd_q;
                  wb_data_q <= align_rdata;
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
               wb_valid_q  <= 1'b0;
               wb_we_q     <= 1'b0;
               wb_rd_q     <= '0;
               wb_data_q   <= '0;
               exc_q       <= 1'b0;
               exc_cause_q <= EXC_NONE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign mem_valid = mem_valid_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_valid  = wb_valid_q;
   assign wb_we     = wb_we_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign exc       = exc_q;
   assign exc_cause = exc_cause_q;

endmodule

// File: tb/tb_tinyriscv_lsu.sv
// Self-checking bench for tinyriscv_lsu: directed cases plus randomized
// transactions against an arithmetic reference model and a scripted memory.
module tb_tinyriscv_lsu;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [6:0]  req_opcode;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_valid, mem_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_rvalid, mem_err;
   logic        wb_valid, wb_we, exc;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [1:0]  exc_cause;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   tinyriscv_lsu #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_err(mem_err),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc(exc), .exc_cause(exc_cause)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      int unsigned cause;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] wbdata;
      bit          we;
   } exp_t;

   function automatic exp_t model(input bit st, input int unsigned f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rdata, input bit err);
      exp_t        e;
      int unsigned off = addr % 4;
      int unsigned sz  = f3 % 4;
      logic [31:0] v   = rdata >> (8 * off);
      logic [31:0] val;
      if (st ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7)) e.cause = 2;
      else if ((sz == 1 && off % 2 == 1) || (sz == 2 && off != 0)) e.cause = 1;
      else if (err) e.cause = 3;
      else e.cause = 0;
      if (sz == 0)      e.be = 4'(1 << off);
      else if (sz == 1) e.be = 4'(3 << (off & 2));
      else              e.be = 4'hF;
      if (sz == 0)      e.wdata = (wd % 256) * 32'h0101_0101;
      else if (sz == 1) e.wdata = (wd % 65536) * 32'h0001_0001;
      else              e.wdata = wd;
      case (f3)
         0:       val = (v % 256 >= 128) ? (v % 256) + 32'hFFFF_FF00 : v % 256;
         4:       val = v % 256;
         1:       val = (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
         5:       val = v % 65536;
         default: val = rdata;
      endcase
      e.we     = !st && e.cause == 0;
      e.wbdata = e.we ? val : 32'h0;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge of the first idle cycle afterwards.
   task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input bit err,
                         input int unsigned rdly, input int unsigned rvdly, input logic [4:0] rd);
      exp_t        e = model(st, int'(f3), addr, wd, rdata, err);
      bit          early = (e.cause == 1 || e.cause == 2);
      int unsigned cyc_wb = early ? 1 : 3 + rdly + rvdly;
      int unsigned w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         check_eq("req_ready_timeout", {31'b0, req_ready}, 32'd1);
         return;
      end
      req_valid  = 1'b1;
      req_opcode = st ? OP_STORE : OP_LOAD;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_rd     = rd;
      for (int unsigned cyc = 1; cyc <= cyc_wb + 1; cyc++) begin
         @(negedge clk);
         req_valid  = 1'b0;
         mem_ready  = 1'b0;
         mem_rvalid = 1'b0;
         mem_err    = 1'b0;
         mem_rdata  = $urandom;
         if (cyc <= cyc_wb) check_eq("req_ready_busy", {31'b0, req_ready}, 32'd0);
         if (cyc < cyc_wb)  check_eq("wb_valid_early", {31'b0, wb_valid}, 32'd0);
         if (early) begin
            if (cyc <= cyc_wb) check_eq("mem_valid_exc", {31'b0, mem_valid}, 32'd0);
         end else if (cyc <= 1 + rdly) begin
            check_eq("mem_valid_req", {31'b0, mem_valid}, 32'd1);
            check_eq("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check_eq("mem_be", {28'b0, mem_be}, {28'b0, e.be});
            check_eq("mem_we", {31'b0, mem_we}, {31'b0, st});
            if (st) check_eq("mem_wdata", mem_wdata, e.wdata);
            mem_ready = (cyc == 1 + rdly);
            if (cyc < 1 + rdly) begin
               mem_rvalid = 1'b1;
               mem_err    = 1'b1;
            end
         end else if (cyc < cyc_wb) begin
            check_eq("mem_valid_wait", {31'b0, mem_valid}, 32'd0);
            if (cyc == cyc_wb - 1) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rdata;
               mem_err    = err;
            end
         end
         if (cyc == cyc_wb) begin
            check_eq("wb_valid", {31'b0, wb_valid}, 32'd1);
            check_eq("wb_we", {31'b0, wb_we}, {31'b0, e.we});
            check_eq("wb_rd", {27'b0, wb_rd}, e.we ? {27'b0, rd} : 32'd0);
            check_eq("wb_data", wb_data, e.wbdata);
            check_eq("exc", {31'b0, exc}, (e.cause != 0) ? 32'd1 : 32'd0);
            check_eq("exc_cause", {30'b0, exc_cause}, e.cause);
            mem_rvalid = 1'b1;
            mem_err    = 1'b1;
         end
         if (cyc == cyc_wb + 1) begin
            check_eq("wb_valid_pulse", {31'b0, wb_valid}, 32'd0);
            check_eq("req_ready_back", {31'b0, req_ready}, 32'd1);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      check_eq({tag, "_mem_valid"}, {31'b0, mem_valid}, 32'd0);
      check_eq({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
      check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
      check_eq({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
      check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check_eq({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
      check_eq({tag, "_wb_we"}, {31'b0, wb_we}, 32'd0);
      check_eq({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'd0);
      check_eq({tag, "_wb_data"}, wb_data, 32'd0);
      check_eq({tag, "_exc"}, {30'b0, exc_cause, exc} , 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_opcode = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      do_txn(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0, 5'd1);
      do_txn(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 0, 5'd2);
      do_txn(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 0, 5'd3);
      do_txn(1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1'b0, 0, 0, 5'd4);
      do_txn(1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 1'b0, 0, 0, 5'd5);
      do_txn(1'b0, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 0, 0, 5'd6);
      do_txn(1'b0, 3'd5, 32'h0000_0302, 32'h0, 32'h8001_7FFF, 1'b1, 3, 2, 5'd7);
      do_txn(1'b1, 3'd0, 32'h0000_0401, 32'hFFFF_FF5A, 32'h0, 1'b0, 1, 1, 5'd8);

      // Reset while waiting for the read response.
      req_valid = 1'b1; req_opcode = OP_LOAD; req_funct3 = 3'd2; req_addr = 32'h40; req_rd = 5'd9;
      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      check_eq("rst_mid_wait", {31'b0, mem_valid}, 32'd0);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         check_eq("late_rvalid_wb", {31'b0, wb_valid}, 32'd0);
         check_eq("late_rvalid_ready", {31'b0, req_ready}, 32'd1);
      end
      do_txn(1'b0, 3'd1, 32'h0000_0042, 32'h0, 32'h8765_4321, 1'b0, 0, 0, 5'd10);

      for (int n = 0; n < 80; n++) begin
         do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                5'($urandom_range(0, 31)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
